// File: rtl/wiscf15_pkg.sv
// Shared WISC-F15 definitions: ALU func codes, branch condition codes and halt FSM states.
package wiscf15_pkg;

  localparam logic [3:0] FN_ADD    = 4'b0000;
  localparam logic [3:0] FN_PADDSB = 4'b0001;
  localparam logic [3:0] FN_SUB    = 4'b0010;
  localparam logic [3:0] FN_NAND   = 4'b0011;
  localparam logic [3:0] FN_XOR    = 4'b0100;
  localparam logic [3:0] FN_SLL    = 4'b0101;
  localparam logic [3:0] FN_SRL    = 4'b0110;
  localparam logic [3:0] FN_SRA    = 4'b0111;
  localparam logic [3:0] FN_LW     = 4'b1000;
  localparam logic [3:0] FN_SW     = 4'b1001;
  localparam logic [3:0] FN_HLT    = 4'b1111;

  localparam logic [2:0] CC_NEQ    = 3'b000;
  localparam logic [2:0] CC_EQ     = 3'b001;
  localparam logic [2:0] CC_GT     = 3'b010;
  localparam logic [2:0] CC_LT     = 3'b011;
  localparam logic [2:0] CC_GTE    = 3'b100;
  localparam logic [2:0] CC_LTE    = 3'b101;
  localparam logic [2:0] CC_OVFL   = 3'b110;
  localparam logic [2:0] CC_UNCOND = 3'b111;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_DRAIN  = 2'b01,
    ST_HALTED = 2'b10
  } halt_state_t;

  function automatic logic writes_vzn(input logic [3:0] func);
    return (func == FN_ADD) || (func == FN_SUB);
  endfunction

  function automatic logic writes_z_only(input logic [3:0] func);
    return (func == FN_NAND) || (func == FN_XOR) || (func == FN_SLL) ||
           (func == FN_SRL)  || (func == FN_SRA);
  endfunction

endpackage

// File: rtl/wiscf15_cond_eval.sv
// Combinational branch condition check of V/Z/N flags against a 3-bit ccc.
module wiscf15_cond_eval
  import wiscf15_pkg::*;
(
  input  logic       v,
  input  logic       z,
  input  logic       n,
  input  logic [2:0] cond,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (cond)
      CC_NEQ:    taken = !z;
      CC_EQ:     taken = z;
      CC_GT:     taken = !z && !n;
      CC_LT:     taken = n;
      CC_GTE:    taken = z || (!z && !n);
      CC_LTE:    taken = n || z;
      CC_OVFL:   taken = v;
      CC_UNCOND: taken = 1'b1;
      default:   taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/wiscf15_flag_branch.sv
// Flag register, branch resolver and HLT drain sequencer. Define WISCF15_FLAG_BYPASS_EN to
// forward same-cycle ALU flags to the branch instead of holding it for one cycle.
module wiscf15_flag_branch
  import wiscf15_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        ex_valid,
  input  logic [3:0]  ex_func,
  input  logic        alu_v,
  input  logic        alu_z,
  input  logic        alu_n,
  input  logic        br_valid,
  input  logic [2:0]  br_cond,
  input  logic [15:0] br_target,
  output logic        br_ready,
  output logic        take_branch,
  output logic [15:0] redirect_pc,
  output logic        flag_v,
  output logic        flag_z,
  output logic        flag_n,
  output logic        halt_req,
  output logic        halted
);

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  halt_state_t state;
  logic [3:0]  drain_cnt;

  logic run, ex_go, wr_vzn, wr_any;
  logic next_v, next_z, next_n;
  logic eval_v, eval_z, eval_n;
  logic hazard_hold, br_taken;

  assign run    = (state == ST_RUN);
  assign ex_go  = ex_valid && !stall && run;
  assign wr_vzn = ex_go && writes_vzn(ex_func);
  assign wr_any = wr_vzn || (ex_go && writes_z_only(ex_func));

  assign next_v = wr_vzn ? alu_v : flag_v;
  assign next_z = wr_any ? alu_z : flag_z;
  assign next_n = wr_vzn ? alu_n : flag_n;

`ifdef WISCF15_FLAG_BYPASS_EN
  assign eval_v      = next_v;
  assign eval_z      = next_z;
  assign eval_n      = next_n;
  assign hazard_hold = 1'b0;
`else
  // Registered flags are stale while EX is writing them; decode retries next cycle.
  assign eval_v      = flag_v;
  assign eval_z      = flag_z;
  assign eval_n      = flag_n;
  assign hazard_hold = br_valid && wr_any;
`endif

  assign br_ready = br_valid && !stall && !flush && run && !hazard_hold;

  wiscf15_cond_eval u_cond_eval (
    .v     (eval_v),
    .z     (eval_z),
    .n     (eval_n),
    .cond  (br_cond),
    .taken (br_taken)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      flag_v      <= 1'b0;
      flag_z      <= 1'b0;
      flag_n      <= 1'b0;
      take_branch <= 1'b0;
      redirect_pc <= 16'h0000;
      state       <= ST_RUN;
      drain_cnt   <= 4'd0;
    end else begin
      flag_v <= next_v;
      flag_z <= next_z;
      flag_n <= next_n;

      if (br_ready) begin
        take_branch <= br_taken;
        redirect_pc <= br_target;
      end else begin
        take_branch <= 1'b0;
      end

      case (state)
        ST_RUN: begin
          if (ex_go && (ex_func == FN_HLT)) begin
            state     <= ST_DRAIN;
            drain_cnt <= DRAIN_LOAD;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == 4'd0) state <= ST_HALTED;
          else                   drain_cnt <= drain_cnt - 4'd1;
        end
        ST_HALTED: state <= ST_HALTED;
        default:   state <= ST_RUN;
      endcase
    end
  end

  assign halt_req = (state != ST_RUN);
  assign halted   = (state == ST_HALTED);

endmodule

// File: tb/tb_wiscf15_flag_branch.sv
// Self-checking bench for wiscf15_flag_branch: directed scenarios plus randomized traffic vs a reference model.
module tb_wiscf15_flag_branch;

  localparam int DRAIN = 3;

  logic        clk = 1'b0;
  logic        rst, stall, flush, ex_valid, alu_v, alu_z, alu_n, br_valid;
  logic [3:0]  ex_func;
  logic [2:0]  br_cond;
  logic [15:0] br_target;
  logic        br_ready, take_branch, flag_v, flag_z, flag_n, halt_req, halted;
  logic [15:0] redirect_pc;
  logic [21:0] dut_outs;

  int checks = 0;
  int errors = 0;

  // Reference model state, kept in architectural terms.
  bit          m_v, m_z, m_n, m_take, hlt_seen;
  logic [15:0] m_pc;
  int          hlt_edge, cyc;

  wiscf15_flag_branch #(.DRAIN_CYCLES(DRAIN)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_func(ex_func), .alu_v(alu_v), .alu_z(alu_z), .alu_n(alu_n),
    .br_valid(br_valid), .br_cond(br_cond), .br_target(br_target),
    .br_ready(br_ready), .take_branch(take_branch), .redirect_pc(redirect_pc),
    .flag_v(flag_v), .flag_z(flag_z), .flag_n(flag_n),
    .halt_req(halt_req), .halted(halted)
  );

  always #5 clk = ~clk;

  assign dut_outs = {take_branch, redirect_pc, flag_v, flag_z, flag_n, halt_req, halted};

  function automatic bit cond_ok(input logic [2:0] c, input bit v, input bit z, input bit n);
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || (!z && !n);
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic bit m_flag_wr();
    return ex_valid && !stall && !hlt_seen && (ex_func inside {4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7});
  endfunction

  function automatic bit m_ready();
    bit r;
    r = br_valid && !stall && !flush && !hlt_seen;
`ifndef WISCF15_FLAG_BYPASS_EN
    if (m_flag_wr()) r = 1'b0;
`endif
    return r;
  endfunction

  function automatic logic [21:0] m_outs();
    bit h;
    h = hlt_seen && (cyc >= hlt_edge + DRAIN);
    return {m_take, m_pc, m_v, m_z, m_n, hlt_seen, h};
  endfunction

  // Advance the model with the inputs currently applied, then clock the DUT.
  task automatic step();
    bit nv, nz, nn, t;
    if (rst) begin
      {m_v, m_z, m_n, m_take, hlt_seen} = '0;
      m_pc = 16'h0;
      hlt_edge = 0;
    end else begin
      nv = m_v; nz = m_z; nn = m_n;
      if (m_flag_wr()) begin
        nz = alu_z;
        if (ex_func == 4'd0 || ex_func == 4'd2) begin
          nv = alu_v;
          nn = alu_n;
        end
      end
`ifdef WISCF15_FLAG_BYPASS_EN
      t = cond_ok(br_cond, nv, nz, nn);
`else
      t = cond_ok(br_cond, m_v, m_z, m_n);
`endif
      if (m_ready()) begin
        m_take = t;
        m_pc   = br_target;
      end else begin
        m_take = 1'b0;
      end
      if (!hlt_seen && ex_valid && !stall && ex_func == 4'hF) begin
        hlt_seen = 1'b1;
        hlt_edge = cyc + 1;
      end
      m_v = nv; m_z = nz; m_n = nn;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ev, input logic [3:0] f, input logic v, input logic z,
                       input logic n, input logic bv, input logic [2:0] c,
                       input logic [15:0] tg, input logic st, input logic fl);
    ex_valid = ev; ex_func = f; alu_v = v; alu_z = z; alu_n = n;
    br_valid = bv; br_cond = c; br_target = tg; stall = st; flush = fl;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1, 4'd0, 1, 1, 1, 1, 3'd7, 16'hFFFF, 0, 0);
    step();
    step();
    checks++;
    if (dut_outs !== 22'h0) begin
      errors++; $display("FAIL reset_outs got %h exp %h", dut_outs, 22'h0);
    end
    rst = 1'b0;
    drive(0, 4'd0, 0, 0, 0, 1, 3'd7, 16'h0, 0, 0);
    checks++;
    if (br_ready !== 1'b1) begin
      errors++; $display("FAIL reset_run_ready got %b exp 1", br_ready);
    end
  endtask

  task automatic test_flags();
    drive(1, 4'd0, 1, 0, 1, 0, 3'd0, 16'h0, 0, 0);  // ADD
    step();
    checks++;
    if ({flag_v, flag_z, flag_n} !== 3'b101) begin
      errors++; $display("FAIL flags_add got %b exp 101", {flag_v, flag_z, flag_n});
    end
    drive(1, 4'd4, 0, 1, 0, 0, 3'd0, 16'h0, 0, 0);  // XOR
    step();
    checks++;
    if ({flag_v, flag_z, flag_n} !== 3'b111) begin
      errors++; $display("FAIL flags_xor got %b exp 111", {flag_v, flag_z, flag_n});
    end
    drive(1, 4'd1, 0, 0, 0, 0, 3'd0, 16'h0, 0, 0);  // PADDSB writes nothing
    step();
    checks++;
    if ({flag_v, flag_z, flag_n} !== 3'b111) begin
      errors++; $display("FAIL flags_paddsb got %b exp 111", {flag_v, flag_z, flag_n});
    end
  endtask

  task automatic test_branch();
    drive(0, 4'd0, 0, 0, 0, 1, 3'd1, 16'h0040, 0, 0);
    checks++;
    if (br_ready !== 1'b1) begin
      errors++; $display("FAIL br_eq_ready got %b exp 1", br_ready);
    end
    step();
    checks++;
    if ({take_branch, redirect_pc} !== {1'b1, 16'h0040}) begin
      errors++; $display("FAIL br_eq_taken got %b/%h exp 1/0040", take_branch, redirect_pc);
    end
    drive(0, 4'd0, 0, 0, 0, 1, 3'd0, 16'h0040, 0, 0);
    step();
    checks++;
    if (take_branch !== 1'b0) begin
      errors++; $display("FAIL br_neq_nottaken got %b exp 0", take_branch);
    end
  endtask

  task automatic test_hazard();
    drive(1, 4'd0, 0, 0, 0, 0, 3'd0, 16'h0, 0, 0);  // ADD clears Z
    step();
    drive(1, 4'd2, 0, 1, 0, 1, 3'd1, 16'h1234, 0, 0);  // SUB Z=1 with branch EQ
`ifdef WISCF15_FLAG_BYPASS_EN
    checks++;
    if (br_ready !== 1'b1) begin
      errors++; $display("FAIL hazard_bypass_ready got %b exp 1", br_ready);
    end
    step();
`else
    checks++;
    if (br_ready !== 1'b0) begin
      errors++; $display("FAIL hazard_hold_ready got %b exp 0", br_ready);
    end
    step();
    checks++;
    if (take_branch !== 1'b0) begin
      errors++; $display("FAIL hazard_bubble got %b exp 0", take_branch);
    end
    drive(0, 4'd0, 0, 0, 0, 1, 3'd1, 16'h1234, 0, 0);
    checks++;
    if (br_ready !== 1'b1) begin
      errors++; $display("FAIL hazard_retry_ready got %b exp 1", br_ready);
    end
    step();
`endif
    checks++;
    if ({take_branch, redirect_pc} !== {1'b1, 16'h1234}) begin
      errors++; $display("FAIL hazard_taken got %b/%h exp 1/1234", take_branch, redirect_pc);
    end
  endtask

  task automatic test_stall_flush();
    drive(1, 4'd0, 1, 0, 1, 1, 3'd7, 16'h0BAD, 1, 0);
    checks++;
    if (br_ready !== 1'b0) begin
      errors++; $display("FAIL stall_ready got %b exp 0", br_ready);
    end
    step();
    checks++;
    if ({flag_v, flag_z, flag_n, take_branch} !== 4'b0100) begin
      errors++; $display("FAIL stall_hold got %b exp 0100", {flag_v, flag_z, flag_n, take_branch});
    end
    drive(0, 4'd0, 0, 0, 0, 1, 3'd7, 16'h0BAD, 0, 1);
    step();
    checks++;
    if ({take_branch, redirect_pc} !== {1'b0, 16'h1234}) begin
      errors++; $display("FAIL flush_drop got %b/%h exp 0/1234", take_branch, redirect_pc);
    end
    drive(1, 4'd2, 1, 0, 1, 1, 3'd7, 16'h0BAD, 1, 1);
    step();
    checks++;
    if ({flag_v, flag_z, flag_n, take_branch} !== 4'b0100) begin
      errors++; $display("FAIL stall_flush got %b exp 0100", {flag_v, flag_z, flag_n, take_branch});
    end
  endtask

  task automatic test_halt();
    drive(1, 4'hF, 0, 0, 0, 0, 3'd0, 16'h0, 0, 0);
    step();
    checks++;
    if ({halt_req, halted} !== 2'b10) begin
      errors++; $display("FAIL halt_req got %b exp 10", {halt_req, halted});
    end
    drive(1, 4'd0, 1, 0, 1, 1, 3'd7, 16'h0F00, 1, 0);  // stall must not delay the drain
    step();
    drive(1, 4'd0, 1, 0, 1, 1, 3'd7, 16'h0F00, 0, 0);
    checks++;
    if (br_ready !== 1'b0) begin
      errors++; $display("FAIL halt_no_ready got %b exp 0", br_ready);
    end
    step();
    checks++;
    if (halted !== 1'b0) begin
      errors++; $display("FAIL halt_early got %b exp 0", halted);
    end
    step();
    checks++;
    if ({halt_req, halted, flag_v, flag_z, flag_n, take_branch} !== 6'b110100) begin
      errors++; $display("FAIL halt_done got %b exp 110100", {halt_req, halted, flag_v, flag_z, flag_n, take_branch});
    end
    step();
    checks++;
    if (dut_outs !== m_outs()) begin
      errors++; $display("FAIL halt_sticky got %h exp %h", dut_outs, m_outs());
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (dut_outs !== 22'h0) begin
      errors++; $display("FAIL halt_rst got %h exp 0", dut_outs);
    end
  endtask

  task automatic test_rst_drain();
    drive(1, 4'hF, 0, 0, 0, 0, 3'd0, 16'h0, 0, 0);
    step();
    drive(0, 4'd0, 0, 0, 0, 0, 3'd0, 16'h0, 0, 0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (dut_outs !== 22'h0) begin
      errors++; $display("FAIL drain_rst got %h exp 0", dut_outs);
    end
    drive(0, 4'd0, 0, 0, 0, 1, 3'd7, 16'h0077, 0, 0);
    checks++;
    if (br_ready !== 1'b1) begin
      errors++; $display("FAIL drain_rst_run got %b exp 1", br_ready);
    end
    step();
    checks++;
    if ({take_branch, redirect_pc} !== {1'b1, 16'h0077}) begin
      errors++; $display("FAIL drain_rst_branch got %b/%h exp 1/0077", take_branch, redirect_pc);
    end
  endtask

  task automatic test_random();
    logic [3:0] f;
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      f = 4'($urandom_range(0, 15));
      if (f == 4'hF && $urandom_range(0, 3) != 0) f = 4'd0;
      drive(1'($urandom_range(0, 1)), f, 1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom_range(0, 1)), 3'($urandom), 16'($urandom),
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0));
      if (!rst) begin
        checks++;
        if (br_ready !== m_ready()) begin
          errors++; $display("FAIL rand_ready cyc %0d got %b exp %b", cyc, br_ready, m_ready());
        end
      end
      step();
      checks++;
      if (dut_outs !== m_outs()) begin
        errors++; $display("FAIL rand_outs cyc %0d got %h exp %h", cyc, dut_outs, m_outs());
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    cyc = 0;
    test_reset();
    test_flags();
    test_branch();
    test_hazard();
    test_stall_flush();
    test_halt();
    test_rst_drain();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wiscf15_flag_branch.md
# wiscf15_flag_branch

Flag register, branch resolver and halt sequencer for the WISC-F15 pipeline. It sits after the ALU and captures the ALU's V/Z/N outputs according to per-opcode update rules. It evaluates the 3-bit branch condition of a branch in decode against those flags, produces a registered taken/redirect result, and sequences HLT into a sticky halted state.

## Interface
- DRAIN_CYCLES, 3, cycles between HLT acceptance and `halted` assertion (1..15)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  pipeline stall; freezes flag updates and branch acceptance
- flush  in  1  cancels the branch presented or held this cycle
- ex_valid  in  1  ALU result in EX is valid this cycle
- ex_func  in  4  ALU func code of the EX instruction
- alu_v, alu_z, alu_n  in  1 each  ALU flag outputs
- br_valid  in  1  branch in decode requests evaluation
- br_cond  in  3  condition code ccc
- br_target  in  16  computed target PC
- br_ready  out  1  branch accepted this cycle
- take_branch  out  1  registered: accepted branch is taken
- redirect_pc  out  16  registered target, valid when `take_branch`=1
- flag_v, flag_z, flag_n  out  1 each  architectural flags
- halt_req  out  1  stop fetch; asserted from HLT acceptance onward
- halted  out  1  sticky halt indication

## Operation
- Flag update when `ex_valid && !stall` and the FSM is in RUN:
  - ADD (0000) and SUB (0010) write V, Z and N.
  - NAND (0011), XOR (0100), SLL (0101), SRL (0110) and SRA (0111) write Z only; V and N hold.
  - PADDSB (0001), LW (1000), SW (1001), HLT (1111) and all other codes write nothing.
- Condition evaluation, where F denotes the effective flags:
  - 000 NEQ: !Z
  - 001 EQ: Z
  - 010 GT: !Z & !N
  - 011 LT: N
  - 100 GTE: Z | (!Z & !N)
  - 101 LTE: N | Z
  - 110 OVFL: V
  - 111 UNCOND: 1
- Branch acceptance: `br_ready` = `br_valid && !stall && !flush && state==RUN && !hazard_hold`.
- When a branch is accepted, `take_branch` and `redirect_pc` register on the next edge. Otherwise `take_branch` registers 0 and `redirect_pc` holds.
- Halt FSM:
  - RUN → DRAIN on `ex_valid && ex_func==1111 && !stall`. The counter loads DRAIN_CYCLES-1.
  - In DRAIN the counter decrements each cycle (stall has no effect). At 0 the FSM moves to HALTED.
  - HALTED is absorbing until `rst`.
  - In DRAIN and HALTED, `ex_valid` and `br_valid` are ignored and `br_ready`=0.
- Reset values: flags 0, `take_branch` 0, `redirect_pc` 0, `halt_req` 0, `halted` 0, FSM in RUN, `hazard_hold` 0.
- `rst` mid-DRAIN or mid-hold returns everything to reset values on that edge.

## Timing
- Flags are visible at the outputs one cycle after the updating EX cycle.
- Branch result latency is 1 cycle after `br_ready`. Back-to-back branches are allowed when no hazard applies.
- `halt_req` is high in the cycle after HLT acceptance.
- `halted` rises exactly DRAIN_CYCLES cycles after that edge.
- Simultaneous `stall` and `flush`: `flush` wins for the branch (dropped). Flags hold due to `stall`.
- `flush` during a hazard hold clears the hold and no result is produced.

## Configuration
- `WISCF15_FLAG_BYPASS_EN` defined:
  - The branch evaluates against the next-state flags, i.e. the same-cycle ALU update is forwarded.
  - `hazard_hold` is tied to 0.
- `WISCF15_FLAG_BYPASS_EN` undefined:
  - The branch evaluates registered flags only.
  - If `br_valid` coincides with a flag-writing EX op (`ex_valid && !stall`), `hazard_hold` sets for one cycle and `br_ready`=0.
  - The branch is accepted the following cycle against the updated flags.

## Structure
- Shared package `wiscf15_pkg`:
  - func-code constants (ADD…SW, HLT)
  - ccc constants
  - halt-FSM state enum
- One sub-module, `wiscf15_cond_eval`: combinational V/Z/N × ccc → taken.

## Test plan
- ADD with alu_v=1, alu_z=0, alu_n=1, then XOR with alu_z=1 → flags V=1, Z=1, N=1 (XOR preserved V and N).
- Registered Z=1, branch ccc=001, target 0x0040 → `br_ready`=1; next cycle `take_branch`=1, `redirect_pc`=0x0040. Same branch with ccc=000 → `take_branch`=0.
- Same-cycle SUB (alu_z=1) plus branch EQ, with Z previously 0:
  - bypass build: taken with no bubble.
  - non-bypass build: `br_ready`=0 for one cycle, then taken.
- `stall`=1 with ADD and `br_valid` → flags unchanged, `br_ready`=0. `flush`=1 with branch UNCOND → `take_branch`=0 next cycle.
- HLT accepted, DRAIN_CYCLES=3 → `halt_req`=1 next cycle, `halted`=1 three cycles after acceptance. A subsequent ADD does not alter flags. `rst` clears `halted`.
- `rst` asserted during DRAIN (counter=1) → FSM in RUN, all outputs 0 next cycle.
